// File: rtl/anspwm_pkg.sv
// rtl/anspwm_pkg.sv - shared widths, types and the error-feedback quantizer function
package anspwm_pkg;

  localparam int TW_DEF = 32;
  localparam int QW_DEF = 16;

  typedef logic [TW_DEF-1:0] target_t;
  typedef logic [QW_DEF-1:0] quant_t;

  typedef struct packed {
    quant_t  quant;
    target_t diff;
  } ns_result_t;

  // Residual is taken against the raw target, not the corrected sum; all math wraps mod 2^TW.
  function automatic ns_result_t ns_quant(input target_t target, input target_t corr);
    target_t    tmp;
    ns_result_t r;
    tmp     = target + corr;
    r.quant = tmp[TW_DEF-1 -: QW_DEF];
    r.diff  = target - {r.quant, {(TW_DEF-QW_DEF){1'b0}}};
    return r;
  endfunction

endpackage

// File: rtl/ns_quant_scheduler_arb.sv
// rtl/ns_quant_scheduler_arb.sv - combinational round-robin arbiter; pointer held by parent
module rr_arbiter #(
  parameter  int N  = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic          i_en,
  input  logic [IW-1:0] i_ptr,
  output logic [N-1:0]  o_gnt,
  output logic [IW-1:0] o_gnt_idx
);

  // Search starts just after the last winner so that winner has lowest priority.
  always_comb begin
    logic found;
    int   idx;
    o_gnt     = '0;
    o_gnt_idx = '0;
    found     = 1'b0;
    idx       = 0;
    for (int i = 1; i <= N; i++) begin
      idx = (int'(i_ptr) + i) % N;
      if (i_en && !found && i_req[idx]) begin
        found          = 1'b1;
        o_gnt[idx]     = 1'b1;
        o_gnt_idx      = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/ns_quant_scheduler.sv
// rtl/ns_quant_scheduler.sv - one noise-shaping quantizer shared round-robin by NCH channels
module ns_quant_scheduler
  import anspwm_pkg::*;
#(
  parameter  int NCH = 4,
  parameter  int TW  = TW_DEF,
  parameter  int QW  = QW_DEF,
  localparam int CW  = $clog2(NCH)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [NCH-1:0]    i_req_valid,
  output logic [NCH-1:0]    o_req_ready,
  input  logic [NCH*TW-1:0] i_req_target,
  input  logic [NCH-1:0]    i_clear_err,
  output logic              o_out_valid,
  input  logic              i_out_ready,
  output logic [CW-1:0]     o_out_ch,
  output logic [QW-1:0]     o_out_quant,
  output logic [TW-1:0]     o_out_diff
);

  logic [TW-1:0] r_corr [NCH];
  logic [CW-1:0] r_rr_ptr;
  logic          r_out_valid;
  logic [CW-1:0] r_out_ch;
  logic [QW-1:0] r_out_quant;
  logic [TW-1:0] r_out_diff;

  logic          w_adv;
  logic          w_en;
  logic          w_xfer;
  logic [NCH-1:0] w_gnt;
  logic [CW-1:0] w_gnt_idx;
  logic [TW-1:0] w_target;
  logic [TW-1:0] w_corr;
  ns_result_t    w_res;

  assign w_adv = !r_out_valid || i_out_ready;
  assign w_en  = w_adv && !i_rst;

  rr_arbiter #(.N(NCH)) u_arb (
    .i_req     (i_req_valid),
    .i_en      (w_en),
    .i_ptr     (r_rr_ptr),
    .o_gnt     (w_gnt),
    .o_gnt_idx (w_gnt_idx)
  );

  assign w_xfer      = |w_gnt;
  assign o_req_ready = w_gnt;

  // Read and write-back of corr happen in the same stage, so back-to-back ops need no bypass.
  assign w_target = i_req_target[w_gnt_idx*TW +: TW];
  assign w_corr   = r_corr[w_gnt_idx];
  assign w_res    = ns_quant(target_t'(w_target), target_t'(w_corr));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rr_ptr    <= CW'(NCH-1);
      r_out_valid <= 1'b0;
      r_out_ch    <= '0;
      r_out_quant <= '0;
      r_out_diff  <= '0;
    end else if (w_adv) begin
      r_out_valid <= w_xfer;
      if (w_xfer) begin
        r_rr_ptr    <= w_gnt_idx;
        r_out_ch    <= w_gnt_idx;
        r_out_quant <= QW'(w_res.quant);
        r_out_diff  <= TW'(w_res.diff);
      end
    end
  end

  // A clear on the same edge as a write-back to that channel wins.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int c = 0; c < NCH; c++) r_corr[c] <= '0;
    end else begin
      for (int c = 0; c < NCH; c++) begin
        if (i_clear_err[c]) begin
          r_corr[c] <= '0;
        end else if (w_gnt[c]) begin
          r_corr[c] <= TW'(w_res.diff);
        end
      end
    end
  end

  assign o_out_valid = r_out_valid;
  assign o_out_ch    = r_out_ch;
  assign o_out_quant = r_out_quant;
  assign o_out_diff  = r_out_diff;

endmodule
